register_file_mp: RTL and testbench

//  Next-generation core register file: parametrised read-port count, one general write port,

---
 rtl/register_file_pkg.sv | 9 +
 rtl/register_file_mp_if.sv | 30 +++
 rtl/register_file_scoreboard.sv | 42 ++++
 rtl/register_file_mp.sv | 73 +++++++
 tb/tb_register_file_mp.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/register_file_pkg.sv
// register_file_pkg: shared constants, stack-op encoding and decode helper for register_file_mp.
package register_file_pkg;
    localparam int STACK_REG_INDEX = 0;
    typedef enum logic [1:0] {STACK_NONE, STACK_LOAD, STACK_PUSH, STACK_POP} stack_op_t;
    // push and pop together cancel out, so they decode to no stack change
    function automatic stack_op_t stack_decode(input logic load, input logic push, input logic pop);
        return load ? STACK_LOAD : (push && !pop) ? STACK_PUSH : (pop && !push) ? STACK_POP : STACK_NONE;
    endfunction
endpackage

// File: rtl/register_file_mp_if.sv
// register_file_mp_if: decode/writeback/stack bus of the multi-port register file.
interface register_file_mp_if #(
    parameter int ADDR_WIDTH_RF  = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_READ_PORTS = 2
);
    logic [NUM_READ_PORTS*ADDR_WIDTH_RF-1:0] read_address;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0]    read_data;
    logic [NUM_READ_PORTS-1:0]               read_busy;
    logic                                    general_write_enable;
    logic [ADDR_WIDTH_RF-1:0]                write_address;
    logic [DATA_WIDTH-1:0]                   write_data;
    logic                                    issue_enable;
    logic [ADDR_WIDTH_RF-1:0]                issue_address;
    logic                                    stack_load_enable;
    logic [DATA_WIDTH-1:0]                   stack_load_data;
    logic                                    stack_push;
    logic                                    stack_pop;
    logic [DATA_WIDTH-1:0]                   stack_pointer;
    modport master (
        output read_address, general_write_enable, write_address, write_data,
               issue_enable, issue_address, stack_load_enable, stack_load_data, stack_push, stack_pop,
        input  read_data, read_busy, stack_pointer
    );
    modport slave (
        input  read_address, general_write_enable, write_address, write_data,
               issue_enable, issue_address, stack_load_enable, stack_load_data, stack_push, stack_pop,
        output read_data, read_busy, stack_pointer
    );
endinterface

// File: rtl/register_file_scoreboard.sv
// register_file_scoreboard: per-register busy bits with issue-set / writeback-clear and read lookups.
// REGISTER_FILE_BYPASS_EN selects post-edge busy state for the lookups.
module register_file_scoreboard
    import register_file_pkg::*;
#(
    parameter int ADDR_WIDTH_RF  = 5,
    parameter int NUM_READ_PORTS = 2
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic                                    issue_enable_i,
    input  logic [ADDR_WIDTH_RF-1:0]                issue_address_i,
    input  logic                                    clear_enable_i,
    input  logic [ADDR_WIDTH_RF-1:0]                clear_address_i,
    input  logic                                    stack_clear_i,
    input  logic [NUM_READ_PORTS*ADDR_WIDTH_RF-1:0] read_address_i,
    output logic [NUM_READ_PORTS-1:0]               read_busy_o
);
    localparam int DEPTH = 2**ADDR_WIDTH_RF;
    logic [DEPTH-1:0] busy_q, busy_d, busy_src;
    // issue is applied last so a newer producer wins over a same-cycle writeback
    always_comb begin
        busy_d = busy_q;
        if (clear_enable_i) busy_d[clear_address_i] = 1'b0;
        if (stack_clear_i) busy_d[STACK_REG_INDEX] = 1'b0;
        if (issue_enable_i) busy_d[issue_address_i] = 1'b1;
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) busy_q <= '0;
        else busy_q <= busy_d;
    end
`ifdef REGISTER_FILE_BYPASS_EN
    assign busy_src = reset_i ? busy_q : busy_d;
`else
    assign busy_src = busy_q;
`endif
    always_comb begin
        read_busy_o = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++)
            read_busy_o[p] = busy_src[read_address_i[p*ADDR_WIDTH_RF +: ADDR_WIDTH_RF]];
    end
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-read-port register file with hardware stack pointer in reg 0 and busy scoreboard.
// REGISTER_FILE_BYPASS_EN enables write-through forwarding of this cycle's write to the read ports.
module register_file_mp
    import register_file_pkg::*;
#(
    parameter int                  ADDR_WIDTH_RF   = 5,
    parameter int                  DATA_WIDTH      = 32,
    parameter int                  NUM_READ_PORTS  = 2,
    parameter int                  STACK_STEP      = 4,
    parameter logic [DATA_WIDTH-1:0] STACK_RESET_VAL = '0
) (
    input logic              clk_i,
    input logic              reset_i,
    register_file_mp_if.slave bus
);
    localparam int DEPTH = 2**ADDR_WIDTH_RF;
    localparam logic [ADDR_WIDTH_RF-1:0] SP_ADDR = ADDR_WIDTH_RF'(STACK_REG_INDEX);
    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DATA_WIDTH-1:0] rd_src [DEPTH];
    logic [DATA_WIDTH-1:0] sp_q, sp_d;
    stack_op_t stack_op;
    logic stack_any;
    assign stack_op  = stack_decode(bus.stack_load_enable, bus.stack_push, bus.stack_pop);
    assign stack_any = bus.stack_load_enable | bus.stack_push | bus.stack_pop;
    assign sp_q      = regs_q[STACK_REG_INDEX];
    // any stack activity, including a cancelling push+pop, blocks a general write to reg 0
    always_comb begin
        sp_d = stack_op == STACK_LOAD ? bus.stack_load_data :
               stack_op == STACK_PUSH ? sp_q - DATA_WIDTH'(STACK_STEP) :
               stack_op == STACK_POP  ? sp_q + DATA_WIDTH'(STACK_STEP) :
               (bus.general_write_enable && bus.write_address == SP_ADDR && !stack_any) ? bus.write_data : sp_q;
        regs_d = regs_q;
        if (bus.general_write_enable && bus.write_address != SP_ADDR) regs_d[bus.write_address] = bus.write_data;
        regs_d[STACK_REG_INDEX] = sp_d;
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            regs_q[STACK_REG_INDEX] <= STACK_RESET_VAL;
        end else begin
            regs_q <= regs_d;
        end
    end
`ifdef REGISTER_FILE_BYPASS_EN
    always_comb begin
        if (reset_i) rd_src = regs_q;
        else rd_src = regs_d;
    end
`else
    assign rd_src = regs_q;
`endif
    always_comb begin
        bus.read_data = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++)
            bus.read_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_src[bus.read_address[p*ADDR_WIDTH_RF +: ADDR_WIDTH_RF]];
    end
    assign bus.stack_pointer = sp_q;
    register_file_scoreboard #(
        .ADDR_WIDTH_RF (ADDR_WIDTH_RF),
        .NUM_READ_PORTS(NUM_READ_PORTS)
    ) u_scoreboard (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .issue_enable_i (bus.issue_enable),
        .issue_address_i(bus.issue_address),
        .clear_enable_i (bus.general_write_enable),
        .clear_address_i(bus.write_address),
        .stack_clear_i  (stack_any),
        .read_address_i (bus.read_address),
        .read_busy_o    (bus.read_busy)
    );
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed and random checks of register_file_mp against a queue-fed reference model.
module tb_register_file_mp;
    localparam int AW = 5, DW = 32, NRP = 2, STEP = 4;
    localparam logic [31:0] RV = 32'h1000;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    register_file_mp_if #(.ADDR_WIDTH_RF(AW), .DATA_WIDTH(DW), .NUM_READ_PORTS(NRP)) bus();
    register_file_mp #(
        .ADDR_WIDTH_RF(AW), .DATA_WIDTH(DW), .NUM_READ_PORTS(NRP), .STACK_STEP(STEP), .STACK_RESET_VAL(RV)
    ) dut (.clk_i(clk), .reset_i(rst), .bus(bus));
    typedef struct { string tag; logic [31:0] val; } exp_t;
    exp_t q[$];
    int errors = 0, checks = 0;
    logic [31:0] m [32], nm [32];
    bit mb [32], nb [32];
    task automatic expect_v(string tag, logic [31:0] v);
        q.push_back('{tag, v});
    endtask
    task automatic check_v(logic [31:0] obs);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_underflow observed=%h", obs);
            return;
        end
        e = q.pop_front();
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
        end
    endtask
    task automatic idle();
        bus.general_write_enable = 0; bus.write_address = '0; bus.write_data = '0;
        bus.issue_enable = 0; bus.issue_address = '0;
        bus.stack_load_enable = 0; bus.stack_load_data = '0; bus.stack_push = 0; bus.stack_pop = 0;
    endtask
    task automatic model_next();
        bit stk;
        nm = m; nb = mb;
        if (rst) begin
            foreach (nm[i]) begin nm[i] = '0; nb[i] = 0; end
            nm[0] = RV;
            return;
        end
        stk = bus.stack_load_enable | bus.stack_push | bus.stack_pop;
        if (bus.general_write_enable) begin
            if (bus.write_address != 0) nm[bus.write_address] = bus.write_data;
            nb[bus.write_address] = 0;
        end
        if (bus.stack_load_enable) nm[0] = bus.stack_load_data;
        else if (bus.stack_push && !bus.stack_pop) nm[0] = m[0] - STEP;
        else if (bus.stack_pop && !bus.stack_push) nm[0] = m[0] + STEP;
        else if (bus.general_write_enable && bus.write_address == 0 && !stk) nm[0] = bus.write_data;
        if (stk) nb[0] = 0;
        if (bus.issue_enable) nb[bus.issue_address] = 1;
    endtask
    task automatic tick();
        model_next();
        @(posedge clk);
        #1;
        m = nm; mb = nb;
    endtask
    task automatic read_chk(string tag, int a0, int a1);
        bus.read_address = {AW'(a1), AW'(a0)};
        #1;
        model_next();
`ifdef REGISTER_FILE_BYPASS_EN
        expect_v({tag, "_d0"}, nm[a0]); expect_v({tag, "_d1"}, nm[a1]);
        expect_v({tag, "_b0"}, {31'b0, nb[a0]}); expect_v({tag, "_b1"}, {31'b0, nb[a1]});
`else
        expect_v({tag, "_d0"}, m[a0]); expect_v({tag, "_d1"}, m[a1]);
        expect_v({tag, "_b0"}, {31'b0, mb[a0]}); expect_v({tag, "_b1"}, {31'b0, mb[a1]});
`endif
        expect_v({tag, "_sp"}, m[0]);
        check_v(bus.read_data[0 +: DW]); check_v(bus.read_data[DW +: DW]);
        check_v({31'b0, bus.read_busy[0]}); check_v({31'b0, bus.read_busy[1]});
        check_v(bus.stack_pointer);
    endtask
    task automatic fixed_chk(string tag, logic [31:0] obs, logic [31:0] req);
        expect_v(tag, req);
        check_v(obs);
    endtask
    initial begin
        rst = 1;
        idle();
        bus.read_address = '0;
        foreach (m[i]) begin m[i] = '0; mb[i] = 0; end
        m[0] = RV;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        read_chk("reset", 0, 5);
        fixed_chk("reset_sp_const", bus.stack_pointer, 32'h1000);
        bus.general_write_enable = 1; bus.write_address = 3; bus.write_data = 32'h1234;
        bus.issue_enable = 1; bus.issue_address = 9;
        tick(); idle();
        read_chk("pre_rst", 3, 9);
        bus.general_write_enable = 1; bus.write_address = 3; bus.write_data = 32'hAAAA;
        bus.stack_push = 1;
        #2 rst = 1;
        foreach (m[i]) begin m[i] = '0; mb[i] = 0; end
        m[0] = RV;
        read_chk("mid_rst", 3, 9);
        fixed_chk("mid_rst_r3", bus.read_data[0 +: DW], 32'h0);
        tick();
        rst = 0; idle();
        read_chk("post_rst", 3, 0);
        bus.general_write_enable = 1; bus.write_address = 5; bus.write_data = 32'hDEAD;
        read_chk("wr_same", 5, 5);
`ifndef REGISTER_FILE_BYPASS_EN
        fixed_chk("wr_same_const", bus.read_data[0 +: DW], 32'h0);
`endif
        tick(); idle();
        read_chk("wr_next", 5, 0);
        fixed_chk("wr_next_const", bus.read_data[0 +: DW], 32'hDEAD);
        bus.issue_enable = 1; bus.issue_address = 7;
        tick(); idle();
        read_chk("issue7", 7, 5);
        fixed_chk("issue7_busy", {31'b0, bus.read_busy[0]}, 32'h1);
        bus.general_write_enable = 1; bus.write_address = 7; bus.write_data = 32'h77;
        bus.issue_enable = 1; bus.issue_address = 7;
        tick(); idle();
        read_chk("setwins", 7, 7);
        fixed_chk("setwins_busy", {31'b0, bus.read_busy[1]}, 32'h1);
        bus.general_write_enable = 1; bus.write_address = 7; bus.write_data = 32'h78;
        bus.issue_enable = 1; bus.issue_address = 8;
        tick(); idle();
        read_chk("diffaddr", 7, 8);
        bus.stack_load_enable = 1; bus.stack_load_data = 32'h0;
        tick(); idle();
        read_chk("sp_load0", 0, 1);
        bus.stack_push = 1;
        tick(); idle();
        fixed_chk("sp_wrap", bus.stack_pointer, 32'hFFFF_FFFC);
        bus.stack_push = 1; bus.stack_pop = 1;
        bus.general_write_enable = 1; bus.write_address = 0; bus.write_data = 32'h99;
        tick(); idle();
        read_chk("sp_pushpop", 0, 7);
        bus.stack_load_enable = 1; bus.stack_load_data = 32'h20; bus.stack_push = 1;
        tick(); idle();
        fixed_chk("sp_load_pri", bus.stack_pointer, 32'h20);
        bus.stack_load_enable = 1; bus.stack_load_data = 32'h1000;
        tick(); idle();
        bus.general_write_enable = 1; bus.write_address = 0; bus.write_data = 32'h55;
        bus.stack_pop = 1;
        tick(); idle();
        fixed_chk("sp_pop_pri", bus.stack_pointer, 32'h1004);
        read_chk("sp_pop", 0, 0);
        bus.issue_enable = 1; bus.issue_address = 0;
        tick(); idle();
        read_chk("busy_r0", 0, 3);
        bus.stack_push = 1;
        tick(); idle();
        read_chk("push_clr_r0", 0, 3);
        for (int c = 0; c < 3000; c++) begin
            int a0, a1;
            idle();
            bus.general_write_enable = $urandom_range(0, 1);
            bus.write_address = AW'($urandom_range(0, 31));
            bus.write_data = $urandom;
            bus.issue_enable = ($urandom_range(0, 2) == 0);
            bus.issue_address = ($urandom_range(0, 3) == 0) ? bus.write_address : AW'($urandom_range(0, 31));
            bus.stack_load_enable = ($urandom_range(0, 15) == 0);
            bus.stack_load_data = $urandom;
            bus.stack_push = ($urandom_range(0, 7) == 0);
            bus.stack_pop = ($urandom_range(0, 7) == 0);
            a0 = ($urandom_range(0, 3) == 0) ? int'(bus.write_address) : $urandom_range(0, 31);
            a1 = ($urandom_range(0, 3) == 0) ? a0 : $urandom_range(0, 31);
            read_chk($sformatf("rnd%0d", c), a0, a1);
            tick();
        end
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
